// File: rtl/reset_pkg.sv
// -----------------------------------------------------------------------------
// reset_pkg
// Shared definitions for the reset source controller:
//   reset_state_t  - controller FSM state encoding
//   CAUSE_*        - bit positions inside the 5-bit sticky cause mask
//   cause_mask()   - packs the per-source activity flags into a cause mask
// -----------------------------------------------------------------------------
package reset_pkg;

  typedef enum logic [1:0] {
    ASSERT     = 2'd0,
    WAIT_CLEAR = 2'd1,
    RUN        = 2'd2
  } reset_state_t;

  localparam int CAUSE_W   = 5;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_BTN = 1;
  localparam int CAUSE_PLL = 2;
  localparam int CAUSE_SW  = 3;
  localparam int CAUSE_WDG = 4;

  // Power-on cause value loaded by the global reset.
  localparam logic [CAUSE_W-1:0] CAUSE_POR_ONLY = CAUSE_W'(1) << CAUSE_POR;

  // Runtime sources never set the POR bit; only the global reset does.
  function automatic logic [CAUSE_W-1:0] cause_mask(
    input logic btn_act,
    input logic pll_lost,
    input logic sw_req,
    input logic wdg_fire
  );
    logic [CAUSE_W-1:0] mask;
    mask            = '0;
    mask[CAUSE_BTN] = btn_act;
    mask[CAUSE_PLL] = pll_lost;
    mask[CAUSE_SW]  = sw_req;
    mask[CAUSE_WDG] = wdg_fire;
    return mask;
  endfunction

endpackage

// File: rtl/reset_debounce.sv
// -----------------------------------------------------------------------------
// reset_debounce
// Synchronizes an asynchronous level and then debounces it: the filtered
// output only follows the synchronized input after the two have disagreed for
// DEBOUNCE_CYCLES consecutive cycles. Any cycle of agreement clears the count,
// so shorter glitches are dropped.
//
// Parameters
//   SYNC_STAGES      synchronizer depth (>=2)
//   DEBOUNCE_CYCLES  consecutive mismatch cycles needed to take a new level
//   RESET_VALUE      level loaded into the synchronizer and filtered output
// Ports
//   clock   in   system clock
//   reset   in   synchronous, active-high
//   raw     in   asynchronous input level
//   level   out  synchronized, debounced level (registered)
// -----------------------------------------------------------------------------
module reset_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_VALUE     = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  // A single-valued counter would have zero width; keep at least one bit.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level <= RESET_VALUE;
      cnt   <= '0;
    end else if (synced == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      // Mismatch has persisted long enough: accept the new level.
      level <= synced;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reset_source_ctrl.sv
// -----------------------------------------------------------------------------
// reset_source_ctrl
// Upstream reset aggregator feeding the reset stretcher. Four runtime sources
// can request reset: the debounced push-button, loss of PLL lock, a software
// pulse and an internal watchdog. o_reset stays asserted for at least
// HOLD_CYCLES+1 cycles per trigger and then until the button is released and
// the PLL is locked. o_cause keeps a sticky record of what caused the most
// recent reset episode.
//
// FSM
//   ASSERT     : counting the minimum hold; triggers accumulate into o_cause,
//                a software pulse restarts the hold.
//   WAIT_CLEAR : hold satisfied; waiting for button release and PLL lock.
//                A software pulse sends us back to ASSERT (it wins over exit).
//   RUN        : o_reset low; any trigger starts a new episode and replaces
//                o_cause with the new mask.
//
// Parameters
//   SYNC_STAGES      synchronizer depth for async inputs (>=2)
//   DEBOUNCE_CYCLES  button debounce length in cycles
//   HOLD_CYCLES      minimum cycles spent in ASSERT per trigger (>=1)
//   WATCHDOG_CYCLES  cycles without kick before the watchdog fires (>=2)
// Ports
//   i_clock       in   system clock
//   i_reset       in   synchronous, active-high power-on/global reset
//   i_button_n    in   async, active-low reset button
//   i_pll_locked  in   async PLL lock indicator
//   i_sw_reset    in   sync 1-cycle software reset request
//   i_wdg_enable  in   sync level, watchdog armed
//   i_wdg_kick    in   sync pulse, clears the watchdog counter
//   o_reset       out  registered active-high reset request
//   o_cause       out  sticky cause {wdg,sw,pll,button,por}
//   o_state       out  current FSM state, for debug/observation
// -----------------------------------------------------------------------------
module reset_source_ctrl
  import reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 16,
  parameter int WATCHDOG_CYCLES = 100000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_button_n,
  input  logic               i_pll_locked,
  input  logic               i_sw_reset,
  input  logic               i_wdg_enable,
  input  logic               i_wdg_kick,
  output logic               o_reset,
  output logic [CAUSE_W-1:0] o_cause,
  output reset_state_t       o_state
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int WDG_W  = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WDG_W-1:0]  WDG_LAST  = WDG_W'(WATCHDOG_CYCLES - 1);

  reset_state_t           state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [WDG_W-1:0]       wdg_cnt;
  logic [SYNC_STAGES-1:0] pll_sync_q;

  logic                   btn_debounced;
  logic                   btn_act;
  logic                   pll_lost;
  logic                   wdg_active;
  logic                   wdg_fire;
  logic                   trig;
  logic                   sources_quiet;
  logic [CAUSE_W-1:0]     mask;

  assign o_state = state;

  // ---------------------------------------------------------------------------
  // Button: synchronized and debounced. Released (1) out of reset so a button
  // that is idle at power-up does not register as a press.
  // ---------------------------------------------------------------------------
  reset_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VALUE     (1'b1)
  ) u_button_debounce (
    .clock (i_clock),
    .reset (i_reset),
    .raw   (i_button_n),
    .level (btn_debounced)
  );

  assign btn_act = !btn_debounced;

  // ---------------------------------------------------------------------------
  // PLL lock: plain synchronizer, no filtering. The chain starts at 0, so
  // right after reset the PLL reads as unlocked until the lock has propagated
  // through SYNC_STAGES flops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pll_sync_q <= '0;
    end else begin
      pll_sync_q <= {pll_sync_q[SYNC_STAGES-2:0], i_pll_locked};
    end
  end

  assign pll_lost = !pll_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Watchdog: only armed in RUN. Gating the fire on RUN as well as on the
  // counter matters on the cycle we leave RUN for another reason, when the
  // counter may still hold its terminal value for one cycle.
  // A kick beats the terminal count in the same cycle.
  // ---------------------------------------------------------------------------
  assign wdg_active = (state == RUN) && i_wdg_enable;
  assign wdg_fire   = wdg_active && (wdg_cnt == WDG_LAST) && !i_wdg_kick;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wdg_cnt <= '0;
    end else if (!wdg_active || i_wdg_kick || (wdg_cnt == WDG_LAST)) begin
      wdg_cnt <= '0;
    end else begin
      wdg_cnt <= wdg_cnt + WDG_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Trigger aggregation
  // ---------------------------------------------------------------------------
  assign trig          = btn_act || pll_lost || i_sw_reset || wdg_fire;
  assign mask          = cause_mask(btn_act, pll_lost, i_sw_reset, wdg_fire);
  assign sources_quiet = !btn_act && !pll_lost;

  // ---------------------------------------------------------------------------
  // Controller FSM. o_reset is written alongside every state transition so it
  // always equals (next state != RUN), with no combinational output path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ASSERT;
      hold_cnt <= '0;
      o_reset  <= 1'b1;
      o_cause  <= CAUSE_POR_ONLY;
    end else begin
      unique case (state)
        RUN: begin
          if (trig) begin
            // New episode: cause reflects only what started it.
            state    <= ASSERT;
            hold_cnt <= '0;
            o_cause  <= mask;
            o_reset  <= 1'b1;
          end else begin
            o_reset  <= 1'b0;
          end
        end

        ASSERT: begin
          o_reset <= 1'b1;
          if (trig) begin
            o_cause <= o_cause | mask;
          end
          if (i_sw_reset) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= WAIT_CLEAR;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        WAIT_CLEAR: begin
          if (i_sw_reset) begin
            // Software request takes priority over a simultaneous exit.
            state    <= ASSERT;
            hold_cnt <= '0;
            o_cause  <= o_cause | mask;
            o_reset  <= 1'b1;
          end else if (sources_quiet) begin
            state    <= RUN;
            o_reset  <= 1'b0;
          end else begin
            o_reset  <= 1'b1;
          end
        end

        default: begin
          // Unused encoding: recover into a fresh hold.
          state    <= ASSERT;
          hold_cnt <= '0;
          o_reset  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_source_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reset_source_ctrl
// Table of per-cycle vectors for power-on, software reset, hold restart,
// software reset at WAIT_CLEAR exit and PLL loss; followed by hand-written
// sequences for the watchdog and button debounce timing.
// Small parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=4,
// WATCHDOG_CYCLES=16.
// -----------------------------------------------------------------------------
module tb_reset_source_ctrl;
  import reset_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clock = 1'b0;
  logic         reset;
  logic         button_n;
  logic         pll_locked;
  logic         sw_reset;
  logic         wdg_enable;
  logic         wdg_kick;
  logic         rst_out;
  logic [4:0]   cause;
  reset_state_t state;

  always #5 clock = ~clock;

  reset_source_ctrl #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (4),
    .WATCHDOG_CYCLES (16)
  ) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_button_n   (button_n),
    .i_pll_locked (pll_locked),
    .i_sw_reset   (sw_reset),
    .i_wdg_enable (wdg_enable),
    .i_wdg_kick   (wdg_kick),
    .o_reset      (rst_out),
    .o_cause      (cause),
    .o_state      (state)
  );

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         rst;
    logic         btn_n;
    logic         pll;
    logic         sw;
    logic         en;
    logic         kick;
    logic         exp_reset;
    logic [4:0]   exp_cause;
    reset_state_t exp_state;
    string        name;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  task automatic add(input logic rst, input logic btn_n, input logic pll,
                     input logic sw, input logic exp_reset,
                     input logic [4:0] exp_cause, input reset_state_t exp_state,
                     input string name);
    vec_t v;
    v.rst       = rst;
    v.btn_n     = btn_n;
    v.pll       = pll;
    v.sw        = sw;
    v.en        = 1'b0;
    v.kick      = 1'b0;
    v.exp_reset = exp_reset;
    v.exp_cause = exp_cause;
    v.exp_state = exp_state;
    v.name      = name;
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // Driver / checker helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic exp_reset,
                               input logic [4:0] exp_cause,
                               input reset_state_t exp_state);
    check({name, ".o_reset"}, 32'(rst_out), 32'(exp_reset));
    check({name, ".o_cause"}, 32'(cause), 32'(exp_cause));
    check({name, ".state"}, 32'(state), 32'(exp_state));
  endtask

  // Hard stop in case something wedges the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic seen;

    reset      = 1'b1;
    button_n   = 1'b1;
    pll_locked = 1'b1;
    sw_reset   = 1'b0;
    wdg_enable = 1'b0;
    wdg_kick   = 1'b0;

    // Power-on. The PLL synchronizer starts at 0, so the PLL reads as lost for
    // the first two ASSERT cycles and its bit is ORed into the cause.
    add(1, 1, 1, 0, 1, 5'b00001, ASSERT,     "por");
    add(0, 1, 1, 0, 1, 5'b00101, ASSERT,     "por_h1");
    add(0, 1, 1, 0, 1, 5'b00101, ASSERT,     "por_h2");
    add(0, 1, 1, 0, 1, 5'b00101, ASSERT,     "por_h3");
    add(0, 1, 1, 0, 1, 5'b00101, WAIT_CLEAR, "por_wait");
    add(0, 1, 1, 0, 0, 5'b00101, RUN,        "por_run");
    add(0, 1, 1, 0, 0, 5'b00101, RUN,        "idle");
    // Software pulse from RUN: high next edge, low 6 edges after the pulse.
    add(0, 1, 1, 1, 1, 5'b01000, ASSERT,     "sw_hit");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "sw_h1");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "sw_h2");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "sw_h3");
    add(0, 1, 1, 0, 1, 5'b01000, WAIT_CLEAR, "sw_wait");
    add(0, 1, 1, 0, 0, 5'b01000, RUN,        "sw_run");
    // Software pulse during ASSERT restarts the hold count.
    add(0, 1, 1, 1, 1, 5'b01000, ASSERT,     "rs_hit");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "rs_h1");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "rs_h2");
    add(0, 1, 1, 1, 1, 5'b01000, ASSERT,     "rs_restart");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "rs_r1");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "rs_r2");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "rs_r3");
    add(0, 1, 1, 0, 1, 5'b01000, WAIT_CLEAR, "rs_wait");
    // Software pulse on the cycle WAIT_CLEAR would exit: full hold again.
    add(0, 1, 1, 1, 1, 5'b01000, ASSERT,     "wc_sw");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "wc_h1");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "wc_h2");
    add(0, 1, 1, 0, 1, 5'b01000, ASSERT,     "wc_h3");
    add(0, 1, 1, 0, 1, 5'b01000, WAIT_CLEAR, "wc_wait");
    add(0, 1, 1, 0, 0, 5'b01000, RUN,        "wc_run");
    // PLL drops during ASSERT after a software reset; held until relock.
    add(0, 1, 1, 1, 1, 5'b01000, ASSERT,     "pll_sw");
    add(0, 1, 0, 0, 1, 5'b01000, ASSERT,     "pll_drop0");
    add(0, 1, 0, 0, 1, 5'b01000, ASSERT,     "pll_drop1");
    add(0, 1, 0, 0, 1, 5'b01100, ASSERT,     "pll_seen");
    add(0, 1, 0, 0, 1, 5'b01100, WAIT_CLEAR, "pll_wait0");
    add(0, 1, 0, 0, 1, 5'b01100, WAIT_CLEAR, "pll_wait1");
    add(0, 1, 1, 0, 1, 5'b01100, WAIT_CLEAR, "pll_relock0");
    add(0, 1, 1, 0, 1, 5'b01100, WAIT_CLEAR, "pll_relock1");
    add(0, 1, 1, 0, 0, 5'b01100, RUN,        "pll_run");

    for (int i = 0; i < vecs.size(); i++) begin
      reset      = vecs[i].rst;
      button_n   = vecs[i].btn_n;
      pll_locked = vecs[i].pll;
      sw_reset   = vecs[i].sw;
      wdg_enable = vecs[i].en;
      wdg_kick   = vecs[i].kick;
      step();
      check_outputs(vecs[i].name, vecs[i].exp_reset, vecs[i].exp_cause,
                    vecs[i].exp_state);
    end
    sw_reset = 1'b0;

    // Watchdog without kicks: fires on its 16th counting cycle.
    wdg_enable = 1'b1;
    repeat (15) step();
    check("wdg_quiet", 32'(rst_out), 32'd0);
    step();
    check("wdg_fire.o_reset", 32'(rst_out), 32'd1);
    check("wdg_fire.o_cause", 32'(cause), 32'b10000);
    // Still enabled: no counting outside RUN, so it comes back to RUN.
    repeat (5) step();
    check_outputs("wdg_back", 1'b0, 5'b10000, RUN);
    // Counter restarts from zero on entering RUN.
    repeat (15) step();
    check("wdg_again_quiet", 32'(rst_out), 32'd0);
    step();
    check("wdg_again_fire", 32'(rst_out), 32'd1);
    wdg_enable = 1'b0;
    repeat (5) step();
    check_outputs("wdg_off", 1'b0, 5'b10000, RUN);

    // Regular kicks every 10 cycles keep it quiet.
    wdg_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      wdg_kick = (i % 10 == 9);
      step();
      if (rst_out) seen = 1'b1;
    end
    wdg_kick = 1'b0;
    check("wdg_kicked_quiet", 32'(seen), 32'd0);
    wdg_enable = 1'b0;
    step();

    // Kick on the terminal-count cycle wins.
    wdg_enable = 1'b1;
    repeat (15) step();
    wdg_kick = 1'b1;
    step();
    wdg_kick = 1'b0;
    check_outputs("kick_vs_fire", 1'b0, 5'b10000, RUN);
    repeat (15) step();
    check("kick_restarted", 32'(rst_out), 32'd0);
    wdg_enable = 1'b0;
    step();
    check("kick_disabled", 32'(rst_out), 32'd0);

    // Button glitch of 3 cycles is rejected.
    button_n = 1'b0;
    repeat (3) step();
    button_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (rst_out) seen = 1'b1;
    end
    check("btn_glitch", 32'(seen), 32'd0);

    // Button held 20 cycles: reset 7 edges after the fall, held until the
    // debounced release, then one edge to leave WAIT_CLEAR.
    button_n = 1'b0;
    repeat (6) step();
    check("btn_pre", 32'(rst_out), 32'd0);
    step();
    check("btn_assert.o_reset", 32'(rst_out), 32'd1);
    check("btn_assert.o_cause", 32'(cause), 32'b00010);
    repeat (13) step();
    check_outputs("btn_held", 1'b1, 5'b00010, WAIT_CLEAR);
    button_n = 1'b1;
    repeat (6) step();
    check_outputs("btn_releasing", 1'b1, 5'b00010, WAIT_CLEAR);
    step();
    check_outputs("btn_released", 1'b0, 5'b00010, RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
